// File: rtl/scoreboard_ctrl_if.sv
// ---------------------------------------------------------------------------
// scoreboard_ctrl_if
//   Bundles the request/ack handshake of the two score sources, the game-won
//   level and the values going out to the 7-segment scoreboard driver.
//
//   Signals
//     req0   requester 0 (move counter) wants the display; held until ack0
//     val0   16-bit move count, sampled in the ack cycle
//     ack0   one-cycle grant to requester 0
//     req1   requester 1 (elapsed time) wants the display; held until ack1
//     val1   16-bit time value, sampled in the ack cycle
//     ack1   one-cycle grant to requester 1
//     win    level, game has been won
//     score  registered binary value for the scoreboard driver
//     src    source of score (0 = moves, 1 = time)
//     ovf    high while score holds a clamped value
//     blank  display blank enable (1 = digits off)
//
//   Modports
//     master  the game side: drives requests, values and win
//     slave   the controller: answers with acks and display outputs
// ---------------------------------------------------------------------------
interface scoreboard_ctrl_if;
    logic        req0;
    logic [15:0] val0;
    logic        ack0;
    logic        req1;
    logic [15:0] val1;
    logic        ack1;
    logic        win;
    logic [15:0] score;
    logic        src;
    logic        ovf;
    logic        blank;

    modport master (
        output req0, val0, req1, val1, win,
        input  ack0, ack1, score, src, ovf, blank
    );

    modport slave (
        input  req0, val0, req1, val1, win,
        output ack0, ack1, score, src, ovf, blank
    );
endinterface

// File: rtl/scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// scoreboard_ctrl
//   Shares one 7-segment scoreboard between the move counter (requester 0)
//   and the elapsed-time counter (requester 1). Requests are granted with a
//   round-robin tie-break, each granted value stays on the display for at
//   least HOLD_CYC cycles, and values above MAX_SCORE are clamped. While the
//   game is won the last value is frozen and the display blinks with a
//   half-period of BLINK_CYC cycles.
//
//   Parameters
//     HOLD_CYC   minimum cycles a granted value is shown (>= 1)
//     BLINK_CYC  blink half-period in cycles while won (>= 1)
//     MAX_SCORE  clamp ceiling for granted values
//
//   Ports
//     clk  system clock (scoreboard clock domain)
//     rst  synchronous reset, active-high
//     bus  slave side of scoreboard_ctrl_if (requests, acks, display outputs)
// ---------------------------------------------------------------------------
module scoreboard_ctrl #(
    parameter int HOLD_CYC  = 1000,
    parameter int BLINK_CYC = 250,
    parameter int MAX_SCORE = 9999
) (
    input logic              clk,
    input logic              rst,
    scoreboard_ctrl_if.slave bus
);

    // Counters only ever hold 0..N-1, so they are sized for N-1 and never wrap.
    localparam int HOLD_W  = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;
    localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [15:0]        MAX_VAL    = 16'(MAX_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        WIN
    } state_t;

    state_t               state_q,      state_d;
    logic [15:0]          score_q,      score_d;
    logic                 src_q,        src_d;
    logic                 ovf_q,        ovf_d;
    logic                 blank_q,      blank_d;
    logic                 ack0_q,       ack0_d;
    logic                 ack1_q,       ack1_d;
    logic                 last_grant_q, last_grant_d;
    logic [HOLD_W-1:0]    hold_cnt_q,   hold_cnt_d;
    logic [BLINK_W-1:0]   blink_cnt_q,  blink_cnt_d;

    logic                 grant_valid;
    logic                 grant_sel;
    logic [15:0]          grant_val;
    logic                 grant_over;

    // Arbitration: a lone request wins outright; when both are pending the
    // one that was not served last time goes first. The selected value is
    // compared against the ceiling here so the FSM just loads the result.
    always_comb begin
        grant_valid = bus.req0 | bus.req1;
        grant_sel   = 1'b0;
        if (bus.req0 && bus.req1) begin
            grant_sel = ~last_grant_q;
        end else if (bus.req1) begin
            grant_sel = 1'b1;
        end
        grant_val  = grant_sel ? bus.val1 : bus.val0;
        grant_over = (grant_val > MAX_VAL);
    end

    // Next-state and next-output logic. Everything that leaves the block is
    // registered, so this process computes the values loaded on the next edge.
    // A won game takes priority over any pending grant, and leaving WIN drops
    // straight back to IDLE so a waiting request is served on the following
    // edge rather than after a fresh hold period.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        src_d        = src_q;
        ovf_d        = ovf_q;
        blank_d      = blank_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        blink_cnt_d  = blink_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.win) begin
                    state_d     = WIN;
                    blank_d     = 1'b0;
                    blink_cnt_d = '0;
                end else if (grant_valid) begin
                    state_d      = SHOW;
                    ack0_d       = ~grant_sel;
                    ack1_d       = grant_sel;
                    score_d      = grant_over ? MAX_VAL : grant_val;
                    ovf_d        = grant_over;
                    src_d        = grant_sel;
                    last_grant_d = grant_sel;
                    hold_cnt_d   = HOLD_LOAD;
                end
            end
            SHOW: begin
                if (bus.win) begin
                    state_d     = WIN;
                    blank_d     = 1'b0;
                    blink_cnt_d = '0;
                    hold_cnt_d  = '0;
                end else if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            WIN: begin
                if (!bus.win) begin
                    state_d     = IDLE;
                    blank_d     = 1'b0;
                    blink_cnt_d = '0;
                end else if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blank_d     = ~blank_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset puts last_grant at 1 so that
    // requester 0 wins the very first tie, and abandons any hold or blink.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            score_q      <= '0;
            src_q        <= 1'b0;
            ovf_q        <= 1'b0;
            blank_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            last_grant_q <= 1'b1;
            hold_cnt_q   <= '0;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            src_q        <= src_d;
            ovf_q        <= ovf_d;
            blank_q      <= blank_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.score = score_q;
    assign bus.src   = src_q;
    assign bus.ovf   = ovf_q;
    assign bus.blank = blank_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scoreboard_ctrl
//   Bench for scoreboard_ctrl with HOLD_CYC=4, BLINK_CYC=3, MAX_SCORE=9999.
//   A cycle-level reference model tracks the display in terms of "earliest
//   cycle the next grant may happen", "cycle the win began" and the last
//   winner, and every output is compared against it after every edge.
//   Directed steps cover reset, hold timing, round-robin, clamping and the
//   win/blink behaviour, followed by a random phase.
// ---------------------------------------------------------------------------
module tb_scoreboard_ctrl;

    localparam int HOLD  = 4;
    localparam int BLINK = 3;
    localparam int MAXS  = 9999;

    logic clk = 1'b0;
    logic rst = 1'b1;

    scoreboard_ctrl_if bus();

    scoreboard_ctrl #(
        .HOLD_CYC (HOLD),
        .BLINK_CYC(BLINK),
        .MAX_SCORE(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model state.
    int          cyc        = 0;
    int          allowed_at = 0;
    bit          in_win     = 1'b0;
    int          win_start  = 0;
    bit          last_grant = 1'b1;
    logic [15:0] m_score    = '0;
    bit          m_src      = 1'b0;
    bit          m_ovf      = 1'b0;
    bit          m_blank    = 1'b0;
    bit          m_ack0     = 1'b0;
    bit          m_ack1     = 1'b0;

    // Advance the model by one clock edge using the inputs seen at that edge.
    function automatic void modelEdge();
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        if (rst) begin
            m_score    = '0;
            m_src      = 1'b0;
            m_ovf      = 1'b0;
            m_blank    = 1'b0;
            in_win     = 1'b0;
            last_grant = 1'b1;
            allowed_at = cyc + 1;
        end else if (in_win) begin
            if (!bus.win) begin
                in_win     = 1'b0;
                m_blank    = 1'b0;
                allowed_at = cyc + 1;
            end else begin
                m_blank = (((cyc - win_start) / BLINK) % 2) == 1;
            end
        end else if (bus.win) begin
            in_win    = 1'b1;
            win_start = cyc;
            m_blank   = 1'b0;
        end else if (cyc >= allowed_at && (bus.req0 || bus.req1)) begin
            bit g;
            int v;
            if (bus.req0 && bus.req1) g = !last_grant;
            else                      g = bus.req1;
            v = g ? int'(bus.val1) : int'(bus.val0);
            m_score    = (v > MAXS) ? 16'(MAXS) : 16'(v);
            m_ovf      = (v > MAXS);
            m_src      = g;
            last_grant = g;
            if (g) m_ack1 = 1'b1;
            else   m_ack0 = 1'b1;
            allowed_at = cyc + HOLD + 1;
        end
        cyc++;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit
    // later, and a requester whose grant was expected drops its request.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("ack0",  16'(bus.ack0),  16'(m_ack0));
        checkOutput("ack1",  16'(bus.ack1),  16'(m_ack1));
        checkOutput("score", bus.score,      m_score);
        checkOutput("src",   16'(bus.src),   16'(m_src));
        checkOutput("ovf",   16'(bus.ovf),   16'(m_ovf));
        checkOutput("blank", 16'(bus.blank), 16'(m_blank));
        if (m_ack0) bus.req0 = 1'b0;
        if (m_ack1) bus.req1 = 1'b0;
    endtask

    // Drive reset and win; raise a request (with its value) only when asked,
    // so a pending request is never withdrawn before it is acknowledged.
    task automatic applyStimulus(input bit r, input bit w,
                                 input bit q0, input logic [15:0] v0,
                                 input bit q1, input logic [15:0] v1);
        rst     = r;
        bus.win = w;
        if (q0) begin
            bus.req0 = 1'b1;
            bus.val0 = v0;
        end
        if (q1) begin
            bus.req1 = 1'b1;
            bus.val1 = v1;
        end
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Wait (bounded) for the DUT to acknowledge the given requester.
    task automatic waitAck(input bit which, input int max_cyc, output int ack_cyc);
        bit seen;
        seen    = 1'b0;
        ack_cyc = -1;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            tick();
            if ((which ? bus.ack1 : bus.ack0) === 1'b1) begin
                seen    = 1'b1;
                ack_cyc = cyc;
            end
        end
        n_vectors++;
        assert (seen) else begin
            n_miscompares++;
            $error("[TB] FAIL ack%0d_wait: observed no ack expected ack within %0d cycles", which, max_cyc);
        end
    endtask

    function automatic logic [15:0] pickVal();
        case ($urandom_range(0, 5))
            0:       return 16'd0;
            1:       return 16'(MAXS);
            2:       return 16'(MAXS + 1);
            3:       return 16'($urandom_range(0, MAXS));
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        int a1;
        int a2;
        bus.req0 = 1'b0;
        bus.val0 = '0;
        bus.req1 = 1'b0;
        bus.val1 = '0;
        bus.win  = 1'b0;

        $display("[TB] reset and idle");
        applyStimulus(1, 0, 0, 0, 0, 0);
        runCycles(2);
        applyStimulus(0, 0, 0, 0, 0, 0);
        runCycles(3);

        $display("[TB] single requester, hold spacing");
        applyStimulus(0, 0, 1, 16'd5, 0, 0);
        waitAck(0, 3, a1);
        checkOutput("first_ack_latency", 16'(a1), 16'(6));
        applyStimulus(0, 0, 1, 16'd60, 0, 0);
        waitAck(0, 10, a2);
        checkOutput("ack_spacing", 16'(a2 - a1), 16'(HOLD + 1));
        runCycles(2);

        $display("[TB] reset during hold");
        applyStimulus(0, 0, 1, pickVal(), 0, 0);
        waitAck(0, 10, a1);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        runCycles(2);

        $display("[TB] round robin");
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 1, pickVal(), 1, pickVal());
        waitAck(0, 3, a1);
        applyStimulus(0, 0, 1, pickVal(), 0, 0);
        waitAck(1, 10, a2);
        checkOutput("rr_spacing", 16'(a2 - a1), 16'(HOLD + 1));
        applyStimulus(0, 0, 0, 0, 1, pickVal());
        waitAck(0, 10, a1);
        applyStimulus(0, 0, 1, pickVal(), 0, 0);
        waitAck(1, 10, a2);
        runCycles(HOLD + 2);

        $display("[TB] clamping");
        applyStimulus(0, 0, 0, 0, 1, 16'd12000);
        waitAck(1, 10, a1);
        checkOutput("clamp_score", bus.score, 16'd9999);
        checkOutput("clamp_ovf",   16'(bus.ovf), 16'd1);
        applyStimulus(0, 0, 0, 0, 1, 16'd9999);
        waitAck(1, 10, a1);
        checkOutput("edge_ovf", 16'(bus.ovf), 16'd0);
        applyStimulus(0, 0, 0, 0, 1, 16'd2378);
        waitAck(1, 10, a1);
        checkOutput("plain_score", bus.score, 16'd2378);
        runCycles(HOLD + 2);

        $display("[TB] win during show");
        applyStimulus(0, 0, 1, 16'd198, 0, 0);
        waitAck(0, 10, a1);
        tick();
        applyStimulus(0, 1, 0, 0, 1, pickVal());
        runCycles(9);
        checkOutput("win_freeze", bus.score, 16'd198);
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitAck(1, 3, a2);
        runCycles(HOLD + 2);

        $display("[TB] win and request together in idle");
        applyStimulus(0, 1, 1, pickVal(), 0, 0);
        runCycles(4);
        applyStimulus(0, 0, 0, 0, 0, 0);
        runCycles(HOLD + 3);

        $display("[TB] random phase");
        for (int i = 0; i < 500; i++) begin
            bit r;
            bit w;
            bit q0;
            bit q1;
            r  = ($urandom_range(0, 199) == 0);
            w  = ($urandom_range(0, 29) == 0) ? !bus.win : bus.win;
            q0 = !bus.req0 && ($urandom_range(0, 3) == 0);
            q1 = !bus.req1 && ($urandom_range(0, 3) == 0);
            applyStimulus(r, w, q0, pickVal(), q1, pickVal());
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
